// File: rtl/rv32_dmem_arbiter.sv
// rtl/rv32_dmem_arbiter.sv - data-priority fetch/load-store arbiter for the shared data memory port
module rv32_dmem_arbiter #(
   parameter int STARVE_MAX = 4,
   parameter int CNT_W      = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [29:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [29:0] d_addr,
   input  logic [3:0]  d_be,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic [29:0] memif_addr,
   output logic        memif_we,
   output logic [3:0]  memif_be,
   output logic [31:0] memif_wdata,
   input  logic [31:0] memif_rdata
);

   typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_t;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   owner_t           owner;
   logic [CNT_W-1:0] starve_cnt;
   logic             force_if;

   // Data side wins unless fetch has been denied STARVE_MAX cycles in a row.
   assign force_if = (starve_cnt == CNT_MAX);
   assign if_gnt   = if_req & (~d_req | force_if);
   assign d_gnt    = d_req & ~if_gnt;

   always_comb begin
      memif_addr  = '0;
      memif_we    = 1'b0;
      memif_be    = 4'b0000;
      memif_wdata = '0;
      if (if_gnt) begin
         memif_addr = if_addr;
         memif_be   = 4'b1111;
      end else if (d_gnt) begin
         memif_addr  = d_addr;
         memif_we    = d_we;
         memif_be    = d_we ? d_be : 4'b1111;
         memif_wdata = d_we ? d_wdata : 32'h0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         owner      <= OWN_NONE;
         starve_cnt <= '0;
      end else begin
         if (if_gnt)
            owner <= OWN_IF;
         else if (d_gnt && !d_we)
            owner <= OWN_D;
         else
            owner <= OWN_NONE;

         if (if_req && !if_gnt)
            starve_cnt <= (starve_cnt == CNT_MAX) ? CNT_MAX : starve_cnt + CNT_W'(1);
         else
            starve_cnt <= '0;
      end
   end

   // Read data is only routed to the side that owns the outstanding read.
   assign if_rvalid = (owner == OWN_IF);
   assign d_rvalid  = (owner == OWN_D);
   assign if_rdata  = if_rvalid ? memif_rdata : 32'h0;
   assign d_rdata   = d_rvalid  ? memif_rdata : 32'h0;

endmodule
